// File: rtl/brick_pkg.sv
// brick_pkg: shared FSM state type, default field size and width helpers for the brick tracker
package brick_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, CLEARED} state_e;
  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 8;
  function automatic int bw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int ROW_W = bw(ROWS_DEF);
  localparam int COL_W = bw(COLS_DEF);
  localparam int CNT_W = bw(ROWS_DEF * COLS_DEF + 1);
endpackage

// File: rtl/brick_bitmap.sv
// brick_bitmap: ROWS x COLS alive storage with row fill, single-bit clear and bounds-checked reads
module brick_bitmap
  import brick_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  localparam int RW = bw(ROWS),
  localparam int CW = bw(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all,
  input  logic          fill_en,
  input  logic [RW-1:0] fill_row,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_row,
  input  logic [CW-1:0] clr_col,
  output logic          old_bit,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic          rd_alive
);
  // bounds masks avoid constant-folded compares when sizes are powers of two
  localparam logic [2**RW-1:0] ROW_OK = {(2**RW){1'b1}} >> (2**RW - ROWS);
  localparam logic [2**CW-1:0] COL_OK = {(2**CW){1'b1}} >> (2**CW - COLS);
  logic [ROWS-1:0][COLS-1:0] bits_q, bits_d;
  logic rd_ok, clr_ok;
  assign rd_ok    = ROW_OK[rd_row] && COL_OK[rd_col];
  assign clr_ok   = ROW_OK[clr_row] && COL_OK[clr_col];
  assign rd_alive = rd_ok && bits_q[rd_row][rd_col];
  assign old_bit  = clr_ok && bits_q[clr_row][clr_col];
  always_comb begin
    bits_d = bits_q;
    if (clr_all) bits_d = '0;
    else begin
      if (fill_en) bits_d[fill_row] = '1;
      if (clr_en && clr_ok) bits_d[clr_row][clr_col] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bits_q <= '0;
    else bits_q <= bits_d;
endmodule

// File: rtl/brick_tracker.sv
// brick_tracker: brick field FSM, remaining-brick counter and cleared flag
// Optional saturating score when BRICK_SCORE_EN is defined; otherwise score is tied to 0.
module brick_tracker
  import brick_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int SCORE_W = 16,
  parameter int POINTS  = 10,
  localparam int RW = bw(ROWS),
  localparam int CW = bw(COLS),
  localparam int NW = bw(ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_level,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  logic [RW-1:0]      hit_row,
  input  logic [CW-1:0]      hit_col,
  output logic               hit_resp_valid,
  output logic               hit_resp_hit,
  input  logic [RW-1:0]      rd_row,
  input  logic [CW-1:0]      rd_col,
  output logic               rd_alive,
  output logic [NW-1:0]      bricks_left,
  output logic               all_bricks_cleared,
  output logic [SCORE_W-1:0] score
);
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic flag_q, flag_d, rv_q, rv_d, rh_q, rh_d;
  logic accept, fill_en, old_bit, last_row, kill;
  brick_bitmap #(.ROWS(ROWS), .COLS(COLS)) u_bitmap (
    .clk(clk), .rst_n(rst_n), .clr_all(load_level), .fill_en(fill_en), .fill_row(row_q),
    .clr_en(accept), .clr_row(hit_row), .clr_col(hit_col), .old_bit(old_bit),
    .rd_row(rd_row), .rd_col(rd_col), .rd_alive(rd_alive)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    last_row = row_q == RW'(ROWS - 1);
    kill     = accept && old_bit;
    state_d  = load_level ? LOAD :
               (state_q == LOAD && last_row) ? ACTIVE :
               (kill && cnt_q == NW'(1)) ? CLEARED : state_q;
  end
  always_comb begin
    hit_ready = state_q == ACTIVE;
    accept    = hit_valid && hit_ready && !load_level;
    fill_en   = state_q == LOAD && !load_level;
  end
  always_comb begin
    row_d  = (fill_en && !last_row) ? row_q + RW'(1) : '0;
    cnt_d  = load_level ? '0 :
             (fill_en && last_row) ? NW'(ROWS * COLS) :
             (kill && cnt_q != '0) ? cnt_q - NW'(1) : cnt_q;
    flag_d = state_d == CLEARED;
    rv_d   = accept;
    rh_d   = kill;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_q  <= '0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
      rv_q   <= 1'b0;
      rh_q   <= 1'b0;
    end else begin
      row_q  <= row_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      rv_q   <= rv_d;
      rh_q   <= rh_d;
    end
  assign bricks_left        = cnt_q;
  assign all_bricks_cleared = flag_q;
  assign hit_resp_valid     = rv_q;
  assign hit_resp_hit       = rh_q;
`ifdef BRICK_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0] sum;
  always_comb begin
    sum     = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
    score_d = load_level ? '0 : !kill ? score_q : sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) score_q <= '0;
    else score_q <= score_d;
  assign score = score_q;
`else
  assign score = SCORE_W'(POINTS) & '0;
`endif
endmodule

// File: tb/tb_brick_tracker.sv
// tb_brick_tracker: directed checks of load, hits, clearing, abort and reset for brick_tracker
module tb_brick_tracker;
  import brick_pkg::*;
`ifdef BRICK_SCORE_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, load_level = 1'b0, hit_valid = 1'b0;
  logic [ROW_W-1:0] hit_row = '0, rd_row = '0;
  logic [COL_W-1:0] hit_col = '0, rd_col = '0;
  logic hit_ready, resp_v, resp_h, rd_alive, cleared;
  logic [CNT_W-1:0] left;
  logic [15:0] score;
  logic s_ready, s_rv, s_rh, s_alive, s_clr;
  logic [CNT_W-1:0] s_left;
  logic [3:0] s_score;
  int checks = 0, fails = 0;
  brick_tracker dut (
    .clk(clk), .rst_n(rst_n), .load_level(load_level), .hit_valid(hit_valid),
    .hit_ready(hit_ready), .hit_row(hit_row), .hit_col(hit_col), .hit_resp_valid(resp_v),
    .hit_resp_hit(resp_h), .rd_row(rd_row), .rd_col(rd_col), .rd_alive(rd_alive),
    .bricks_left(left), .all_bricks_cleared(cleared), .score(score)
  );
  brick_tracker #(.SCORE_W(4), .POINTS(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load_level(load_level), .hit_valid(hit_valid),
    .hit_ready(s_ready), .hit_row(hit_row), .hit_col(hit_col), .hit_resp_valid(s_rv),
    .hit_resp_hit(s_rh), .rd_row(rd_row), .rd_col(rd_col), .rd_alive(s_alive),
    .bricks_left(s_left), .all_bricks_cleared(s_clr), .score(s_score)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load();
    load_level = 1'b1;
    step();
    load_level = 1'b0;
    repeat (4) step();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({hit_ready, resp_v, resp_h, rd_alive, cleared} !== 5'b0 || left !== '0 || score !== '0) begin
      fails++;
      $display("FAIL reset: ready=%b rv=%b rh=%b alive=%b clr=%b left=%0d score=%0d expected all 0",
               hit_ready, resp_v, resp_h, rd_alive, cleared, left, score);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_load();
    load_level = 1'b1;
    step();
    load_level = 1'b0;
    checks++;
    if (hit_ready !== 1'b0) begin fails++; $display("FAIL load_ready0: got %b expected 0", hit_ready); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (hit_ready !== 1'b0) begin fails++; $display("FAIL load_ready%0d: got %b expected 0", i, hit_ready); end
      if (i == 2) begin
        rd_row = 2'd1; rd_col = 3'd5;
        #1;
        checks++;
        if (rd_alive !== 1'b1) begin fails++; $display("FAIL partial_row1: got %b expected 1", rd_alive); end
        rd_row = 2'd2;
        #1;
        checks++;
        if (rd_alive !== 1'b0) begin fails++; $display("FAIL partial_row2: got %b expected 0", rd_alive); end
      end
    end
    step();
    checks++;
    if (hit_ready !== 1'b1 || left !== 6'd32 || cleared !== 1'b0) begin
      fails++;
      $display("FAIL load_done: ready=%b left=%0d clr=%b expected 1 32 0", hit_ready, left, cleared);
    end
  endtask
  task automatic test_back_to_back();
    hit_valid = 1'b1; hit_row = 2'd1; hit_col = 3'd3;
    rd_row = 2'd1; rd_col = 3'd3;
    step();
    checks++;
    if (resp_v !== 1'b1 || resp_h !== 1'b1 || left !== 6'd31 || rd_alive !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: rv=%b rh=%b left=%0d alive=%b expected 1 1 31 0", resp_v, resp_h, left, rd_alive);
    end
    step();
    hit_valid = 1'b0;
    checks++;
    if (resp_v !== 1'b1 || resp_h !== 1'b0 || left !== 6'd31) begin
      fails++;
      $display("FAIL b2b_second: rv=%b rh=%b left=%0d expected 1 0 31", resp_v, resp_h, left);
    end
    step();
    checks++;
    if (resp_v !== 1'b0 || s_score !== (SC_EN ? 4'd10 : 4'd0)) begin
      fails++;
      $display("FAIL b2b_idle: rv=%b sat_score=%0d expected 0 %0d", resp_v, s_score, SC_EN ? 10 : 0);
    end
  endtask
  task automatic test_clear_all();
    hit_valid = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        hit_row = r[1:0]; hit_col = c[2:0];
        step();
        if (r == 3 && c == 6) begin
          checks++;
          if (cleared !== 1'b0 || left !== 6'd1) begin
            fails++;
            $display("FAIL pre_final: clr=%b left=%0d expected 0 1", cleared, left);
          end
        end
      end
    hit_valid = 1'b0;
    checks++;
    if (resp_v !== 1'b1 || resp_h !== 1'b1 || cleared !== 1'b1 || hit_ready !== 1'b0 || left !== '0) begin
      fails++;
      $display("FAIL final_hit: rv=%b rh=%b clr=%b ready=%b left=%0d expected 1 1 1 0 0",
               resp_v, resp_h, cleared, hit_ready, left);
    end
    checks++;
    if (score !== (SC_EN ? 16'd320 : 16'd0) || s_score !== (SC_EN ? 4'd15 : 4'd0)) begin
      fails++;
      $display("FAIL score: got %0d sat %0d expected %0d sat %0d", score, s_score, SC_EN ? 320 : 0, SC_EN ? 15 : 0);
    end
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    checks++;
    if (resp_v !== 1'b0 || cleared !== 1'b1) begin
      fails++;
      $display("FAIL cleared_hold: rv=%b clr=%b expected 0 1", resp_v, cleared);
    end
  endtask
  task automatic test_load_abort();
    do_load();
    hit_valid = 1'b1;
    for (int i = 0; i < 27; i++) begin
      hit_row = i[4:3]; hit_col = i[2:0];
      step();
    end
    checks++;
    if (left !== 6'd5 || cleared !== 1'b0) begin
      fails++;
      $display("FAIL abort_pre: left=%0d clr=%b expected 5 0", left, cleared);
    end
    hit_row = 2'd3; hit_col = 3'd7;
    load_level = 1'b1;
    step();
    load_level = 1'b0;
    hit_valid = 1'b0;
    checks++;
    if (resp_v !== 1'b0 || hit_ready !== 1'b0 || score !== '0 || cleared !== 1'b0) begin
      fails++;
      $display("FAIL abort_edge: rv=%b ready=%b score=%0d clr=%b expected 0 0 0 0", resp_v, hit_ready, score, cleared);
    end
    repeat (4) step();
    rd_row = 2'd3; rd_col = 3'd7;
    #1;
    checks++;
    if (left !== 6'd32 || score !== '0 || cleared !== 1'b0 || hit_ready !== 1'b1 || rd_alive !== 1'b1) begin
      fails++;
      $display("FAIL abort_reload: left=%0d score=%0d clr=%b ready=%b alive=%b expected 32 0 0 1 1",
               left, score, cleared, hit_ready, rd_alive);
    end
  endtask
  task automatic test_reset_mid_load();
    load_level = 1'b1;
    step();
    load_level = 1'b0;
    repeat (2) step();
    rd_row = 2'd0; rd_col = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_alive !== 1'b0 || left !== '0 || hit_ready !== 1'b0 || resp_v !== 1'b0) begin
      fails++;
      $display("FAIL mid_load_reset: alive=%b left=%0d ready=%b rv=%b expected 0 0 0 0", rd_alive, left, hit_ready, resp_v);
    end
    step();
    rst_n = 1'b1;
    hit_valid = 1'b1;
    repeat (5) step();
    hit_valid = 1'b0;
    checks++;
    if (hit_ready !== 1'b0 || resp_v !== 1'b0 || left !== '0) begin
      fails++;
      $display("FAIL post_reset_idle: ready=%b rv=%b left=%0d expected 0 0 0", hit_ready, resp_v, left);
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_clear_all();
    test_load_abort();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
